// File: rtl/md_pkg.sv
// Shared types for the force writeback path: IDs, the writeback word, and the
// mapping from a 3-D cell coordinate to a flat destination node ID.
package md_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int CELL_ID_WIDTH     = 3;
    localparam int PARTICLE_ID_WIDTH = 7;
    localparam int ID_WIDTH          = 3*CELL_ID_WIDTH + PARTICLE_ID_WIDTH;
    localparam int WB_WIDTH          = ID_WIDTH + 3*DATA_WIDTH;
    localparam int NODE_ID_WIDTH     = 5;
    localparam int unsigned NUM_CELL_X = 3;
    localparam int unsigned NUM_CELL_Y = 3;
    localparam int unsigned NUM_CELL_Z = 3;

    typedef logic [CELL_ID_WIDTH-1:0] cell_id_t;
    typedef logic [NODE_ID_WIDTH-1:0] node_id_t;

    typedef struct packed {
        cell_id_t                     cell_x;
        cell_id_t                     cell_y;
        cell_id_t                     cell_z;
        logic [PARTICLE_ID_WIDTH-1:0] particle_id;
    } full_id_t;

    typedef struct packed {
        full_id_t              id;
        logic [DATA_WIDTH-1:0] fz;
        logic [DATA_WIDTH-1:0] fy;
        logic [DATA_WIDTH-1:0] fx;
    } wb_word_t;

    typedef struct packed {
        logic     is_local;
        node_id_t dest;
        wb_word_t word;
    } fifo_entry_t;

    // Coordinates are 1-based; 0 and anything past the grid edge are invalid.
    function automatic logic coord_in_range(input cell_id_t c, input int unsigned n);
        return (c != '0) && (32'(c) <= n);
    endfunction

    function automatic node_id_t cell_to_node(input cell_id_t cx, input cell_id_t cy,
                                              input cell_id_t cz);
        int unsigned flat;
        flat = ((32'(cz) - 32'd1) * NUM_CELL_Y + (32'(cy) - 32'd1)) * NUM_CELL_X
               + (32'(cx) - 32'd1);
        return node_id_t'(flat);
    endfunction

endpackage

// File: rtl/force_wb_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry one extra wrap bit so
// full and empty fall out of a plain pointer compare.
module force_wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/force_wb_packetizer.sv
// Force writeback packetizer: maps cell ID to destination node, buffers, and steers
// each packet to the local cache or the network. FORCE_WB_STATS_EN adds counters.
module force_wb_packetizer
    import md_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int AF_MARGIN  = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NODE_ID_WIDTH-1:0]          my_node_id,
    input  logic [WB_WIDTH-1:0]               wb_in,
    input  logic                              wb_valid,
    output logic                              wb_ready,
    output logic [NODE_ID_WIDTH+WB_WIDTH-1:0] net_out,
    output logic                              net_valid,
    input  logic                              net_ready,
    output logic [WB_WIDTH-1:0]               local_out,
    output logic                              local_valid,
    input  logic                              local_ready,
    output logic                              coord_err,
    output logic                              ovf_err
`ifdef FORCE_WB_STATS_EN
    ,
    output logic [31:0]                       stat_local_cnt,
    output logic [31:0]                       stat_net_cnt,
    output logic [31:0]                       stat_drop_cnt
`endif
);
    localparam int EW = $bits(fifo_entry_t);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wb_word_t    s0_word;
    logic        s0_valid;
    logic        s0_ok;
    fifo_entry_t s0_entry;
    fifo_entry_t s1_entry;
    logic        s1_valid;

    logic [EW-1:0] head_bits;
    fifo_entry_t   head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_rd;
    logic          drop_ovf;
    logic          drop_coord;
    logic          room_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid <= 1'b0;
            s0_word  <= '0;
        end else begin
            s0_valid <= wb_valid;
            if (wb_valid) s0_word <= wb_word_t'(wb_in);
        end
    end

    always_comb begin
        s0_ok = coord_in_range(s0_word.id.cell_x, NUM_CELL_X)
             && coord_in_range(s0_word.id.cell_y, NUM_CELL_Y)
             && coord_in_range(s0_word.id.cell_z, NUM_CELL_Z);
        s0_entry.dest     = cell_to_node(s0_word.id.cell_x, s0_word.id.cell_y, s0_word.id.cell_z);
        s0_entry.is_local = (s0_entry.dest == my_node_id);
        s0_entry.word     = s0_word;
    end

    assign drop_coord = s0_valid && !s0_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_entry  <= '0;
            coord_err <= 1'b0;
        end else begin
            s1_valid <= s0_valid && s0_ok;
            if (s0_valid && s0_ok) s1_entry <= s0_entry;
            if (drop_coord) coord_err <= 1'b1;
        end
    end

    force_wb_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (s1_valid),
        .wr_data (s1_entry),
        .rd_en   (fifo_rd),
        .rd_data (head_bits),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head        = fifo_entry_t'(head_bits);
    assign local_valid = !fifo_empty && head.is_local;
    assign net_valid   = !fifo_empty && !head.is_local;
    assign local_out   = head.word;
    assign net_out     = {head.dest, head.word};
    assign fifo_rd     = (local_valid && local_ready) || (net_valid && net_ready);
    assign drop_ovf    = s1_valid && fifo_full && !fifo_rd;

    // Words already in S0/S1 will land regardless of ready, so they count as used.
    assign room_ok = (FIFO_DEPTH - int'(fifo_count) - int'(s0_valid) - int'(s1_valid)) > AF_MARGIN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ready <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            wb_ready <= room_ok;
            if (drop_ovf) ovf_err <= 1'b1;
        end
    end

`ifdef FORCE_WB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_local_cnt <= '0;
            stat_net_cnt   <= '0;
            stat_drop_cnt  <= '0;
        end else begin
            if (local_valid && local_ready && stat_local_cnt != '1)
                stat_local_cnt <= stat_local_cnt + 32'd1;
            if (net_valid && net_ready && stat_net_cnt != '1)
                stat_net_cnt <= stat_net_cnt + 32'd1;
            if ((drop_coord || drop_ovf) && stat_drop_cnt != '1)
                stat_drop_cnt <= stat_drop_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/force_wb_packetizer.md
Name: force_wb_packetizer

Overview:
- Sits directly downstream of the force distributor.
- Consumes full-ID force writebacks: particle ID with absolute cell ID, plus x/y/z force.
- Converts the 3-D cell ID to a flat destination node ID and buffers packets in a FIFO.
- Steers each packet to the local force-cache port (destination = own node) or to the network port, each with valid/ready.

Parameters:
- DATA_WIDTH, 32, width of one force component.
- CELL_ID_WIDTH, 3, width of one cell coordinate.
- PARTICLE_ID_WIDTH, 7, particle index width.
- ID_WIDTH, 3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH, full particle ID width.
- WB_WIDTH, ID_WIDTH+3*DATA_WIDTH, input word width.
- NUM_CELL_X / NUM_CELL_Y / NUM_CELL_Z, 3 / 3 / 3, cells per axis; valid coordinates are 1..NUM_CELL_*.
- NODE_ID_WIDTH, 5, flat node ID width.
- FIFO_DEPTH, 16, packet buffer entries (power of two).
- AF_MARGIN, 4, free entries reserved for in-flight words; wb_ready deasserts inside this margin.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- my_node_id  in  NODE_ID_WIDTH  own node ID, static after reset.
- wb_in  in  WB_WIDTH  {full_id, fz, fy, fx}; full_id = {cell_x, cell_y, cell_z, particle_id}.
- wb_valid  in  1  input word valid.
- wb_ready  out  1  space available (drives distributor ready).
- net_out  out  NODE_ID_WIDTH+WB_WIDTH  {dest_node_id, wb word}.
- net_valid  out  1  network packet valid.
- net_ready  in  1  network accepts.
- local_out  out  WB_WIDTH  word for the home force cache.
- local_valid  out  1  local word valid.
- local_ready  in  1  local cache accepts.
- coord_err  out  1  sticky: a word with an out-of-range coordinate was dropped.
- ovf_err  out  1  sticky: a word arrived while the FIFO was full and was dropped.

Behaviour:
- Reset (async assert, sync deassert): all valids 0, wb_ready 0, FIFO empty, both error flags 0, pipeline registers cleared.
- Reset mid-operation discards all buffered words.
- Stage S0: wb_in is registered whenever wb_valid=1. wb_ready is advisory; the upstream block may issue without it.
- Stage S1: dest = ((cz-1)*NUM_CELL_Y + (cy-1))*NUM_CELL_X + (cx-1), truncated to NODE_ID_WIDTH. is_local = (dest == my_node_id). Result registered.
- Coordinate 0 or above NUM_CELL_* on any axis: word dropped at S1, coord_err set, FIFO untouched.
- Stage S2: FIFO write of {is_local, dest, word}, first-word-fall-through.
- Minimum latency: wb_valid at cycle t gives head valid at cycle t+3.
- Full FIFO at write time: word dropped, ovf_err set, FIFO contents unchanged.
- Simultaneous read and write on a full FIFO: pop first, so the write succeeds.
- wb_ready = registered (free_entries - inflight_S0_S1 > AF_MARGIN).
- Output steering from the FIFO head:
  - is_local=1: local_valid=1, net_valid=0; pop when local_ready.
  - is_local=0: net_valid=1, local_valid=0; pop when net_ready.
  - Strict order: a stalled head blocks all later words, no bypass.
- Output valid never drops without its handshake; output data is stable while stalled.
- The FIFO pointer counter uses one extra wrap bit; full/empty is derived from the pointer compare.
- Error flags clear only on reset.

Optional Feature:
- Macro FORCE_WB_STATS_EN.
- When defined, adds outputs stat_local_cnt, stat_net_cnt and stat_drop_cnt, each 32 bit.
  - Local and network counters increment on each completed handshake.
  - Drop counter increments on each coord or overflow drop.
  - All three saturate at all-ones and reset to 0.
- When undefined, none of these ports or registers exist; all other behaviour is identical.

Decomposition:
- md_pkg gains node_id_t, a wb_word_t struct {full_id_t id; force x/y/z}, and function cell_to_node().
- One sub-module: force_wb_fifo, a parameterised FWFT synchronous FIFO exposing count/full/empty.

Test Plan:
- Reset then single word, cell (2,2,2), my_node_id=13 -> local_valid at t+3, local_out equals input, net_valid stays 0.
- Cell (3,1,2) with my_node_id=13 -> net_valid at t+3, dest_node_id=11 ((1*3+0)*3+2).
- Cell (0,2,2) -> no output, coord_err=1, later valid words still forwarded.
- net_ready=0, 20 back-to-back network words -> wb_ready low once 12 entries are committed.
  - Words beyond 16 set ovf_err; the first 16 drain in order once net_ready=1.
- Alternating local/net words with local_ready=0 -> first local word blocks the following net word.
  - Order is preserved after release.
- Assert rst_n low while 5 words are buffered -> all valids 0 immediately, FIFO empty after release.
